// File: rtl/adder_vector_sequencer.sv
// adder_vector_sequencer: replays stored A/B vectors into an adder and tallies sum matches
module adder_vector_sequencer #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_a,
  input  logic [WIDTH-1:0]  load_b,
  input  logic [WIDTH-1:0]  load_exp,
  input  logic              start,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  input  logic [WIDTH-1:0]  sum,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pass_count,
  output logic [ADDR_W:0]   fail_count,
  output logic              fail_seen,
  output logic [ADDR_W-1:0] first_fail_idx
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, CHECK = 3'd3, DONE = 3'd4;
  localparam int CW = $clog2(LAT + 1);
  logic [2:0] state;
  logic [ADDR_W-1:0] idx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_exp [DEPTH];
  logic wr;
  assign wr = rst_n && load_en && !busy && ({1'b0, load_addr} < (ADDR_W+1)'(DEPTH));
  // The store survives reset so a self-test can be rerun after an abort
  always_ff @(posedge clk)
    if (wr) begin
      mem_a[load_addr]   <= load_a;
      mem_b[load_addr]   <= load_b;
      mem_exp[load_addr] <= load_exp;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      A              <= '0;
      B              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            pass_count     <= '0;
            fail_count     <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            done           <= 1'b0;
            idx            <= '0;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        ISSUE: begin
          A     <= mem_a[idx];
          B     <= mem_b[idx];
          cnt   <= CW'(LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt   <= cnt - 1'b1;
          state <= (cnt == CW'(1)) ? CHECK : WAIT;
        end
        CHECK: begin
          if (sum == mem_exp[idx])
            pass_count <= pass_count + 1'b1;
          else begin
            fail_count <= fail_count + 1'b1;
            if (!fail_seen) begin
              first_fail_idx <= idx;
              fail_seen      <= 1'b1;
            end
          end
          // Flags flip on the last check so busy spans exactly DEPTH*(LAT+2) cycles
          if (idx == ADDR_W'(DEPTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ISSUE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_adder_vector_sequencer.sv
// tb_adder_vector_sequencer: two sequencer instances (LAT=1/DEPTH=10, LAT=3/DEPTH=4) against a cycle model
module tb_adder_vector_sequencer;
  localparam int LATS [2] = '{1, 3};
  localparam int DEPS [2] = '{10, 4};
  logic clk = 1'b0;
  logic rst_n, load_en, start;
  logic [3:0] load_addr, load_a, load_b, load_exp;
  logic [3:0] A [2];
  logic [3:0] B [2];
  logic [3:0] sum [2];
  logic busy [2];
  logic done [2];
  logic fail_seen [2];
  logic [4:0] pass_count [2];
  logic [4:0] fail_count [2];
  logic [3:0] first_fail_idx [2];
  int nvec = 0, nerr = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  adder_vector_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_a(load_a),
    .load_b(load_b), .load_exp(load_exp), .start(start), .A(A[0]), .B(B[0]), .sum(sum[0]),
    .busy(busy[0]), .done(done[0]), .pass_count(pass_count[0]), .fail_count(fail_count[0]),
    .fail_seen(fail_seen[0]), .first_fail_idx(first_fail_idx[0]));
  adder_vector_sequencer #(.LAT(3), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_a(load_a),
    .load_b(load_b), .load_exp(load_exp), .start(start), .A(A[1]), .B(B[1]), .sum(sum[1]),
    .busy(busy[1]), .done(done[1]), .pass_count(pass_count[1]), .fail_count(fail_count[1]),
    .fail_seen(fail_seen[1]), .first_fail_idx(first_fail_idx[1]));
  // Registered adders with the latency each instance is configured for
  logic [3:0] s0;
  logic [3:0] p1 [3];
  always @(posedge clk) begin
    s0 <= 4'(A[0] + B[0]);
    p1[0] <= 4'(A[1] + B[1]);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign sum[0] = s0;
  assign sum[1] = p1[2];
  // Behavioural model: cyc counts edges since the accepted start; vector k is issued
  // at edge 2+k*(L+2) and judged at edge 1+(k+1)*(L+2)
  logic [3:0] ma [2][16];
  logic [3:0] mb [2][16];
  logic [3:0] me [2][16];
  int cyc [2] = '{0, 0};
  int epass [2], efail [2], efirst [2];
  bit eseen [2], edone [2];
  logic [3:0] eA [2];
  logic [3:0] eB [2];
  int tot, k, L;
  always @(posedge clk)
    for (int n = 0; n < 2; n++) begin
      L = LATS[n];
      tot = DEPS[n] * (L + 2);
      if (rst_n && load_en && !(cyc[n] >= 1 && cyc[n] <= tot) && int'(load_addr) < DEPS[n]) begin
        ma[n][load_addr] = load_a;
        mb[n][load_addr] = load_b;
        me[n][load_addr] = load_exp;
      end
      if (!rst_n) begin
        cyc[n] = 0; epass[n] = 0; efail[n] = 0; efirst[n] = 0;
        eseen[n] = 0; edone[n] = 0; eA[n] = 0; eB[n] = 0;
      end else if (cyc[n] == 0) begin
        if (start) begin
          cyc[n] = 1; epass[n] = 0; efail[n] = 0; efirst[n] = 0; eseen[n] = 0; edone[n] = 0;
        end
      end else if (cyc[n] == tot + 1)
        cyc[n] = 0;
      else begin
        cyc[n]++;
        if (cyc[n] >= 2 && cyc[n] <= tot && (cyc[n] - 2) % (L + 2) == 0) begin
          k = (cyc[n] - 2) / (L + 2);
          eA[n] = ma[n][k];
          eB[n] = mb[n][k];
        end
        if (cyc[n] >= L + 3 && (cyc[n] - 1) % (L + 2) == 0) begin
          k = (cyc[n] - 1) / (L + 2) - 1;
          if (((ma[n][k] + mb[n][k]) & 15) == me[n][k]) epass[n]++;
          else begin
            efail[n]++;
            if (!eseen[n]) begin eseen[n] = 1; efirst[n] = k; end
          end
        end
        if (cyc[n] == tot + 1) edone[n] = 1;
      end
    end
  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] @%0t got %0h expected %0h", nm, n, $time, act, exp);
    end
  endtask
  always @(negedge clk)
    if (armed)
      for (int n = 0; n < 2; n++) begin
        chk("A", n, 32'(A[n]), 32'(eA[n]));
        chk("B", n, 32'(B[n]), 32'(eB[n]));
        chk("busy", n, 32'(busy[n]), 32'(cyc[n] >= 1 && cyc[n] <= DEPS[n] * (LATS[n] + 2)));
        chk("done", n, 32'(done[n]), 32'(edone[n]));
        chk("pass_count", n, 32'(pass_count[n]), epass[n]);
        chk("fail_count", n, 32'(fail_count[n]), efail[n]);
        chk("fail_seen", n, 32'(fail_seen[n]), 32'(eseen[n]));
        chk("first_fail_idx", n, 32'(first_fail_idx[n]), efirst[n]);
      end
  task automatic load(input int ad, input int a, input int b, input int e);
    load_en = 1; load_addr = 4'(ad); load_a = 4'(a); load_b = 4'(b); load_exp = 4'(e);
    @(negedge clk);
    load_en = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  // Runs both instances; d0/d1 are cycles from the start edge to done, bz the busy cycles of dut0
  task automatic run(output int d0, output int d1, output int bz);
    int t = 0;
    d0 = -1; d1 = -1; bz = 0;
    pulse_start();
    while (t < 300 && (d0 < 0 || d1 < 0)) begin
      bz += int'(busy[0]);
      if (done[0] && d0 < 0) d0 = t;
      if (done[1] && d1 < 0) d1 = t;
      @(negedge clk);
      t++;
    end
    chk("run_timeout", 0, 32'(d0 >= 0 && d1 >= 0), 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic load_base();
    for (int i = 0; i < 10; i++) load(i, i, i + 1, 2 * i + 1);
  endtask
  int d0, d1, bz;
  initial begin
    rst_n = 0; load_en = 0; start = 0; load_addr = 0; load_a = 0; load_b = 0; load_exp = 0;
    @(negedge clk);
    @(negedge clk);
    armed = 1;
    rst_n = 1;
    load_base();
    run(d0, d1, bz);
    chk("t1_busy_cycles", 0, bz, 30);
    chk("t1_done_time", 0, d0, 30);
    chk("t1_done_time", 1, d1, 20);
    chk("t1_pass", 0, 32'(pass_count[0]), 10);
    chk("t1_fail", 0, 32'(fail_count[0]), 0);
    chk("t1_pass", 1, 32'(pass_count[1]), 4);
    load(3, 3, 4, 0);
    load(6, 6, 7, 1);
    run(d0, d1, bz);
    chk("t2_pass", 0, 32'(pass_count[0]), 8);
    chk("t2_fail", 0, 32'(fail_count[0]), 2);
    chk("t2_first", 0, 32'(first_fail_idx[0]), 3);
    chk("t2_seen", 0, 32'(fail_seen[0]), 1);
    chk("t2_fail", 1, 32'(fail_count[1]), 1);
    for (int i = 0; i < 10; i++) load(i, 15, 1, (i % 2) ? 5'h10 : 0);
    run(d0, d1, bz);
    chk("t3_wrap_pass", 0, 32'(pass_count[0]), 10);
    load_base();
    pulse_start();
    repeat (16) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t4_rst_busy", 0, 32'(busy[0]), 0);
    chk("t4_rst_count", 0, 32'(pass_count[0]), 0);
    chk("t4_rst_A", 0, 32'(A[0]), 0);
    run(d0, d1, bz);
    chk("t4_rerun_pass", 0, 32'(pass_count[0]), 10);
    start = 1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    load(0, 9, 9, 9);
    pulse_start();
    repeat (40) @(negedge clk);
    chk("t5_busy_pass", 0, 32'(pass_count[0]), 10);
    run(d0, d1, bz);
    chk("t5_repeat_pass", 0, 32'(pass_count[0]), 10);
    chk("t5_repeat_fail", 0, 32'(fail_count[0]), 0);
    load(0, 2, 2, 4);
    start = 1;
    load(0, 2, 3, 0);
    start = 0;
    repeat (40) @(negedge clk);
    chk("t6_same_edge_first", 0, 32'(first_fail_idx[0]), 0);
    chk("t6_same_edge_fail", 0, 32'(fail_count[0]), 1);
    for (int c = 0; c < 1500; c++) begin
      load_en = ($urandom % 4 == 0);
      load_addr = 4'($urandom);
      load_a = 4'($urandom);
      load_b = 4'($urandom);
      load_exp = ($urandom % 2 == 0) ? 4'(load_a + load_b) : 4'($urandom);
      start = ($urandom % 30 == 0);
      rst_n = ($urandom % 400 != 0);
      @(negedge clk);
    end
    load_en = 0; start = 0; rst_n = 1;
    repeat (50) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
